// File: rtl/alu_pkg.sv
// Shared ALU types and defaults: FSM state encoding, operand widths and shift modes.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 16;
  localparam int AMT_W_DEF = 4;

  localparam logic SH_LOGICAL = 1'b0;
  localparam logic SH_ARITH   = 1'b1;

endpackage

// File: rtl/right_shift_step.sv
// One combinational right-shift step: either a single bit or BIG_STEP bits, with
// the vacated top positions filled from fill_i and the last bit shifted out reported.
module right_shift_step #(
  parameter int WIDTH    = 16,
  parameter int BIG_STEP = 4
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             fill_i,
  input  logic             big_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_o
);

  always_comb begin
    if (big_i) begin
      value_o = {{BIG_STEP{fill_i}}, value_i[WIDTH-1:BIG_STEP]};
      carry_o = value_i[BIG_STEP-1];
    end else begin
      value_o = {fill_i, value_i[WIDTH-1:1]};
      carry_o = value_i[0];
    end
  end

endmodule

// File: rtl/right_shift_unit.sv
// Iterative logical/arithmetic right shifter with valid/ready handshakes; retires
// BIG_STEP bits per cycle while enough distance remains, then single bits.
module right_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int AMT_W    = AMT_W_DEF,
  parameter int BIG_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [AMT_W-1:0] shift_amount,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             big_step;
  logic             fill_bit;
  logic [WIDTH-1:0] step_value;
  logic             step_carry;

  // The MSB of the working register still holds the sign after every step.
  assign big_step = (rem_q >= AMT_W'(BIG_STEP));
  assign fill_bit = (mode_q == SH_ARITH) ? work_q[WIDTH-1] : 1'b0;

  right_shift_step #(
    .WIDTH    (WIDTH),
    .BIG_STEP (BIG_STEP)
  ) u_step (
    .value_i (work_q),
    .fill_i  (fill_bit),
    .big_i   (big_step),
    .value_o (step_value),
    .carry_o (step_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= SH_LOGICAL;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = x;
          rem_d   = shift_amount;
          mode_d  = arith;
          carry_d = 1'b0;
          zero_d  = (x == '0);
          state_d = (shift_amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d  = step_value;
        carry_d = step_carry;
        zero_d  = (step_value == '0);
        rem_d   = big_step ? (rem_q - AMT_W'(BIG_STEP)) : (rem_q - AMT_W'(1));
        if (rem_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = work_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule
